// File: rtl/ternary_dot_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : ternary_dot_accumulator
//  Purpose  : Accumulates LEN ternary-weighted activation beats into one
//             saturating dot product and hands each finished sum to the
//             requantize/writeback stage through a ready/valid register.
//  Revision : 1.0  initial release
// ============================================================================
module ternary_dot_accumulator #(
    parameter int ACT_W = 8,
    parameter int ACC_W = 20,
    parameter int LEN   = 256
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACT_W-1:0] in_act,
    input  logic [1:0]       in_weight,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat,
    output logic             overrun
);

    localparam int              IDX_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    // Accumulation state
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             sat_accum_q, sat_accum_d;

    // Output register and sticky error flag
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q,  out_data_d;
    logic             out_sat_q,   out_sat_d;
    logic             overrun_q,   overrun_d;

    // Datapath wires
    logic [ACC_W:0]   w_act_ext;
    logic [ACC_W:0]   w_term;
    logic [ACC_W:0]   w_sum;
    logic             w_sat_now;
    logic [ACC_W-1:0] w_sum_sat;
    logic             w_idx_last;
    logic             w_accept;

    // Ternary product and saturating add; one guard bit makes the negation of
    // the most negative activation and the overflow test exact.
    always_comb begin
        w_act_ext = {{(ACC_W+1-ACT_W){in_act[ACT_W-1]}}, in_act};
        case (in_weight)
            2'b01:   w_term = w_act_ext;
            2'b11:   w_term = -w_act_ext;
            default: w_term = '0;          // 2'b00 and the reserved 2'b10
        endcase
        w_sum     = {acc_q[ACC_W-1], acc_q} + w_term;
        // Guard bit disagreeing with the result sign bit means out of range
        w_sat_now = w_sum[ACC_W] ^ w_sum[ACC_W-1];
        if (w_sat_now) begin
            w_sum_sat = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            w_sum_sat = w_sum[ACC_W-1:0];
        end
    end

    // Handshake: only the final beat of a vector can be stalled, and only
    // while the previous result is still waiting downstream.
    always_comb begin
        w_idx_last = (idx_q == LAST_IDX);
        in_ready   = !(w_idx_last && out_valid_q && !out_ready);
        w_accept   = in_valid && in_ready;
    end

    // Next-state: accumulate, complete a vector, drain, and flag dropped beats
    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        sat_accum_d = sat_accum_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        overrun_d   = overrun_q;

        // Drain first; a completion in the same cycle overrides it below so
        // back-to-back results never leave a bubble.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            if (w_idx_last) begin
                out_data_d  = w_sum_sat;
                out_sat_d   = sat_accum_q | w_sat_now;
                out_valid_d = 1'b1;
                acc_d       = '0;
                idx_d       = '0;
                sat_accum_d = 1'b0;
            end else begin
                acc_d       = w_sum_sat;
                idx_d       = idx_q + IDX_W'(1);
                sat_accum_d = sat_accum_q | w_sat_now;
            end
        end

        if (in_valid && !in_ready) begin
            overrun_d = 1'b1;
        end
    end

    // State registers with asynchronous reset; a partial vector is discarded
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_q       <= '0;
            idx_q       <= '0;
            sat_accum_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            sat_accum_q <= sat_accum_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: doc/ternary_dot_accumulator.md
Name: ternary_dot_accumulator

Overview:
Consumes the beat stream from the pipelined ternary multiply stage, whose valid is aligned by signal_delay. It accumulates one dot product of LEN elements per vector and presents each finished sum on a ready/valid output register to the requantize/writeback stage. Back-pressure is applied only on the final beat of a vector. Dropped beats are flagged.

Parameters:
ACT_W, 8, activation width (signed two's complement)
ACC_W, 20, accumulator and result width (signed); must be >= ACT_W+1
LEN, 256, elements per dot product; must be >= 1; counter width max(1, $clog2(LEN))

Ports:
clk_in  input  1  clock, all state on posedge
rst_in  input  1  asynchronous, active-high reset
in_valid  input  1  beat present (delayed valid from signal_delay)
in_ready  output  1  beat will be accepted this cycle
in_act  input  ACT_W  signed activation
in_weight  input  2  ternary weight: 2'b01=+1, 2'b11=-1, 2'b00=0, 2'b10=reserved (treated as 0)
out_valid  output  1  result held in output register
out_ready  input  1  downstream takes result this cycle
out_data  output  ACC_W  signed dot-product result
out_sat  output  1  result was clamped at least once during its vector
overrun  output  1  sticky: a beat arrived while in_ready=0

Behaviour:
- Reset: asynchronous, takes effect immediately without a clock edge. acc=0, idx=0, sat_accum=0, out_valid=0, out_data=0, out_sat=0, overrun=0. A partial vector in progress is discarded.
- Accept: a beat is accepted when in_valid && in_ready.
- Term: +in_act, -in_act or 0, sign-extended to ACC_W+1 bits. Negating -2^(ACT_W-1) must yield +2^(ACT_W-1) with no wrap.
- Sum: sum = acc + term, computed in ACC_W+1 bits.
  - Saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - sat_now=1 when the sum is clamped.
  - No wrap-around is ever permitted.
- Accepted beat, idx < LEN-1:
  - acc <= saturated sum; idx <= idx+1; sat_accum <= sat_accum | sat_now.
- Accepted beat, idx == LEN-1 (the final beat):
  - out_data <= saturated sum; out_sat <= sat_accum | sat_now; out_valid <= 1.
  - acc, idx and sat_accum all reset to 0.
  - Latency: a final beat at edge t gives out_valid=1 after edge t.
- LEN=1: every accepted beat completes a vector, and out_data equals that beat's term.
- Output hold: while out_valid && !out_ready, out_data and out_sat are held stable.
- Drain: on out_valid && out_ready with no completion in the same cycle, out_valid <= 0. out_data keeps its last value.
- Drain and completion in the same cycle: the new result is loaded and out_valid stays 1. No bubble, no loss.
- in_ready = !(idx == LEN-1 && out_valid && !out_ready).
  - Combinational from out_ready; this is the only path from out_ready to in_ready.
  - Non-final beats are never stalled.
- Overrun: in_valid && !in_ready sets overrun <= 1.
  - The beat is dropped; acc, idx and the output register are unchanged.
  - overrun clears only on reset.
- No idle-time state changes: with in_valid=0 and no drain, all registers hold.

Test Plan:
1. LEN=4, ACT_W=8, ACC_W=12, out_ready=1; acts 10,20,30,40 with weights +1,-1,+1,+1 -> one cycle after the 4th beat, out_valid pulses for 1 cycle with out_data=60, out_sat=0; in_ready stays 1 throughout.
2. LEN=4, ACC_W=12; act -128 with weight -1 on all 4 beats -> out_data=512. Then act 55 with weights 2'b00,2'b10,2'b00,2'b00 -> out_data=0.
3. Saturation, ACC_W=9, LEN=4; act 127 with weight +1 x4 -> out_data=255, out_sat=1. Next vector acts 1,1,1,1 with weight +1 -> out_data=4, out_sat=0, showing the flag does not carry over.
4. Back-pressure, LEN=4: hold out_ready=0 after the first result.
   - The second vector's first 3 beats are accepted; in_ready=0 on the 4th with in_valid held; out_data stays at the first result.
   - Raise out_ready -> in_ready=1 that cycle and the 4th beat is accepted.
   - Next cycle out_valid=1 with the second result; overrun=0.
5. Overrun: with in_ready=0, drive in_valid=1 for one cycle with act 99 -> overrun=1 and stays 1. The completed sum excludes 99 and idx is unchanged. overrun clears only after rst_in.
6. Reset mid-vector, LEN=4: after 2 beats (acts 5,6, weight +1), assert rst_in between clock edges -> outputs read 0 and in_ready=1 immediately. After release, beats 1,2,3,4 with weight +1 -> out_data=10.
